// File: rtl/tank_pkg.sv
// Shared types and default key codes for the multi-tank motion controller.
// Key codes are USB HID usage IDs for WASD and the arrow cluster.
package tank_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] KEY_W  = 8'h1A;
   localparam logic [7:0] KEY_A  = 8'h04;
   localparam logic [7:0] KEY_S  = 8'h16;
   localparam logic [7:0] KEY_D  = 8'h07;
   localparam logic [7:0] KEY_UP = 8'h52;
   localparam logic [7:0] KEY_DN = 8'h51;
   localparam logic [7:0] KEY_LT = 8'h50;
   localparam logic [7:0] KEY_RT = 8'h4F;

endpackage

// File: rtl/tank_overlap_chk.sv
// Combinational box-overlap test of one candidate tank position against every
// other tank; the tank being moved is excluded by index.
module tank_overlap_chk
   import tank_pkg::*;
#(
   parameter int N_TANKS   = 2,
   parameter int COORD_W   = 10,
   parameter int TANK_SIZE = 16,
   parameter int IDX_W     = 1
) (
   input  logic [COORD_W-1:0]         cand_x,
   input  logic [COORD_W-1:0]         cand_y,
   input  logic [COORD_W*N_TANKS-1:0] all_x,
   input  logic [COORD_W*N_TANKS-1:0] all_y,
   input  logic [IDX_W-1:0]           excl_idx,
   output logic                       hit
);

   localparam logic [COORD_W-1:0] SIZE_C = COORD_W'(TANK_SIZE);

   logic [COORD_W-1:0] oth_x_s;
   logic [COORD_W-1:0] oth_y_s;
   logic [COORD_W-1:0] dx_s;
   logic [COORD_W-1:0] dy_s;

   // Two equal squares overlap when both axis distances are below the edge length.
   always_comb begin
      hit     = 1'b0;
      oth_x_s = '0;
      oth_y_s = '0;
      dx_s    = '0;
      dy_s    = '0;
      for (int i = 0; i < N_TANKS; i++) begin
         oth_x_s = all_x[i*COORD_W +: COORD_W];
         oth_y_s = all_y[i*COORD_W +: COORD_W];
         dx_s    = (cand_x > oth_x_s) ? (cand_x - oth_x_s) : (oth_x_s - cand_x);
         dy_s    = (cand_y > oth_y_s) ? (cand_y - oth_y_s) : (oth_y_s - cand_y);
         if ((excl_idx != IDX_W'(i)) && (dx_s < SIZE_C) && (dy_s < SIZE_C)) begin
            hit = 1'b1;
         end else begin
            hit = hit;
         end
      end
   end

endmodule

// File: rtl/tank_array_ctrl.sv
// Multi-tank motion controller: once per frame, walks the tanks in index order,
// decodes each tank's keys from a latched HID report and commits bounded,
// collision-checked single-axis moves.
module tank_array_ctrl
   import tank_pkg::*;
#(
   parameter int N_TANKS   = 2,
   parameter int N_KEYS    = 6,
   parameter int COORD_W   = 10,
   parameter int TANK_SIZE = 16,
   parameter int STEP      = 1,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 623,
   parameter int Y_MIN     = 0,
   parameter int Y_MAX     = 463,
   parameter logic [COORD_W*N_TANKS-1:0] START_X = {10'd300, 10'd100},
   parameter logic [COORD_W*N_TANKS-1:0] START_Y = {10'd200, 10'd200},
   parameter logic [32*N_TANKS-1:0]      KEYMAP  = {KEY_RT, KEY_DN, KEY_LT, KEY_UP,
                                                    KEY_D,  KEY_S,  KEY_A,  KEY_W}
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         frame_tick,
   input  logic [8*N_KEYS-1:0]          keycodes,
   output logic [COORD_W*N_TANKS-1:0]   tank_x,
   output logic [COORD_W*N_TANKS-1:0]   tank_y,
   output logic [2*N_TANKS-1:0]         tank_dir,
   output logic [N_TANKS-1:0]           blocked,
   output logic                         update_done,
   output logic                         overrun
);

   localparam int IDX_W = (N_TANKS > 1) ? $clog2(N_TANKS) : 1;
   localparam int PW    = COORD_W * N_TANKS;

   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_TANKS - 1);
   localparam logic [COORD_W:0]   STEP_E   = (COORD_W+1)'(STEP);
   localparam logic [COORD_W:0]   X_MIN_E  = (COORD_W+1)'(X_MIN);
   localparam logic [COORD_W:0]   X_MAX_E  = (COORD_W+1)'(X_MAX);
   localparam logic [COORD_W:0]   Y_MIN_E  = (COORD_W+1)'(Y_MIN);
   localparam logic [COORD_W:0]   Y_MAX_E  = (COORD_W+1)'(Y_MAX);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [8*N_KEYS-1:0] key_q, key_d;
   logic [PW-1:0]       x_q, x_d;
   logic [PW-1:0]       y_q, y_d;
   logic [2*N_TANKS-1:0] dir_q, dir_d;
   logic [N_TANKS-1:0]  blocked_q, blocked_d;
   logic                update_done_q, update_done_d;
   logic                overrun_q, overrun_d;

   logic [COORD_W-1:0]  cur_x_s, cur_y_s;
   logic [31:0]         cur_map_s;
   logic                up_s, down_s, left_s, right_s, any_key_s;
   dir_t                new_dir_s;
   logic [COORD_W:0]    dec_x_s, inc_x_s, dec_y_s, inc_y_s;
   logic [COORD_W-1:0]  cand_x_s, cand_y_s;
   logic                hit_s;

   // Pick out the position and key map of the tank currently being evaluated.
   always_comb begin
      cur_x_s   = '0;
      cur_y_s   = '0;
      cur_map_s = '0;
      for (int i = 0; i < N_TANKS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_x_s   = x_q[i*COORD_W +: COORD_W];
            cur_y_s   = y_q[i*COORD_W +: COORD_W];
            cur_map_s = KEYMAP[i*32 +: 32];
         end else begin
            cur_x_s = cur_x_s;
         end
      end
   end

   // Match every non-empty report byte against the tank's four direction codes.
   always_comb begin
      up_s    = 1'b0;
      down_s  = 1'b0;
      left_s  = 1'b0;
      right_s = 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
         if (key_q[8*k +: 8] != 8'h00) begin
            up_s    = up_s    | (key_q[8*k +: 8] == cur_map_s[7:0]);
            left_s  = left_s  | (key_q[8*k +: 8] == cur_map_s[15:8]);
            down_s  = down_s  | (key_q[8*k +: 8] == cur_map_s[23:16]);
            right_s = right_s | (key_q[8*k +: 8] == cur_map_s[31:24]);
         end else begin
            up_s = up_s;
         end
      end
      any_key_s = up_s | down_s | left_s | right_s;
      if (up_s) begin
         new_dir_s = DIR_UP;
      end else if (down_s) begin
         new_dir_s = DIR_DOWN;
      end else if (left_s) begin
         new_dir_s = DIR_LEFT;
      end else begin
         new_dir_s = DIR_RIGHT;
      end
   end

   // Candidate position, with one guard bit so a step past zero is caught rather than wrapped.
   always_comb begin
      dec_x_s  = {1'b0, cur_x_s} - STEP_E;
      inc_x_s  = {1'b0, cur_x_s} + STEP_E;
      dec_y_s  = {1'b0, cur_y_s} - STEP_E;
      inc_y_s  = {1'b0, cur_y_s} + STEP_E;
      cand_x_s = cur_x_s;
      cand_y_s = cur_y_s;
      case (new_dir_s)
         DIR_UP:    cand_y_s = (dec_y_s[COORD_W] || (dec_y_s < Y_MIN_E)) ? Y_MIN_E[COORD_W-1:0]
                                                                         : dec_y_s[COORD_W-1:0];
         DIR_DOWN:  cand_y_s = (inc_y_s > Y_MAX_E) ? Y_MAX_E[COORD_W-1:0] : inc_y_s[COORD_W-1:0];
         DIR_LEFT:  cand_x_s = (dec_x_s[COORD_W] || (dec_x_s < X_MIN_E)) ? X_MIN_E[COORD_W-1:0]
                                                                         : dec_x_s[COORD_W-1:0];
         DIR_RIGHT: cand_x_s = (inc_x_s > X_MAX_E) ? X_MAX_E[COORD_W-1:0] : inc_x_s[COORD_W-1:0];
         default:   cand_x_s = cur_x_s;
      endcase
   end

   tank_overlap_chk #(
      .N_TANKS   (N_TANKS),
      .COORD_W   (COORD_W),
      .TANK_SIZE (TANK_SIZE),
      .IDX_W     (IDX_W)
   ) u_overlap (
      .cand_x   (cand_x_s),
      .cand_y   (cand_y_s),
      .all_x    (x_q),
      .all_y    (y_q),
      .excl_idx (idx_q),
      .hit      (hit_s)
   );

   // Frame sequencer and per-tank commit; earlier commits are already in x_q/y_q for later tanks.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      key_d         = key_q;
      x_d           = x_q;
      y_d           = y_q;
      dir_d         = dir_q;
      blocked_d     = blocked_q;
      update_done_d = 1'b0;
      overrun_d     = overrun_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_tick) begin
               key_d   = keycodes;
               idx_d   = '0;
               state_d = ST_EVAL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EVAL: begin
            overrun_d = overrun_q | frame_tick;
            for (int i = 0; i < N_TANKS; i++) begin
               if ((idx_q == IDX_W'(i)) && any_key_s) begin
                  dir_d[2*i +: 2] = new_dir_s;
                  if ((cand_x_s == cur_x_s) && (cand_y_s == cur_y_s)) begin
                     blocked_d[i] = 1'b0;
                  end else if (hit_s) begin
                     blocked_d[i] = 1'b1;
                  end else begin
                     x_d[i*COORD_W +: COORD_W] = cand_x_s;
                     y_d[i*COORD_W +: COORD_W] = cand_y_s;
                     blocked_d[i]              = 1'b0;
                  end
               end else begin
                  blocked_d[i] = blocked_d[i];
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d       = ST_DONE;
               update_done_d = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            overrun_d = overrun_q | frame_tick;
            idx_d     = '0;
            state_d   = ST_IDLE;
         end
         default: begin
            idx_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         key_q         <= '0;
         x_q           <= START_X;
         y_q           <= START_Y;
         dir_q         <= '0;
         blocked_q     <= '0;
         update_done_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         key_q         <= key_d;
         x_q           <= x_d;
         y_q           <= y_d;
         dir_q         <= dir_d;
         blocked_q     <= blocked_d;
         update_done_q <= update_done_d;
         overrun_q     <= overrun_d;
      end
   end

   assign tank_x      = x_q;
   assign tank_y      = y_q;
   assign tank_dir    = dir_q;
   assign blocked     = blocked_q;
   assign update_done = update_done_q;
   assign overrun     = overrun_q;

endmodule

// File: doc/tank_array_ctrl.md
Name: tank_array_ctrl

Overview:
Parametrised multi-tank motion controller; successor to the per-player tank block. One instance serves N_TANKS players from a shared USB HID keycode report (up to N_KEYS simultaneous keys) and a per-tank key map. It performs bounded, collision-checked movement once per frame and feeds packed positions and facing to the colour mapper.

Parameters:
N_TANKS, 2, number of tanks (1..8)
N_KEYS, 6, keycode bytes in report
COORD_W, 10, coordinate width
TANK_SIZE, 16, square tank edge in pixels
STEP, 1, pixels moved per frame
X_MIN / X_MAX, 0 / 623, legal top-left x range (inclusive)
Y_MIN / Y_MAX, 0 / 463, legal top-left y range (inclusive)
START_X, {10'd300,10'd100}, packed reset x per tank (tank 0 in LSBs)
START_Y, {10'd200,10'd200}, packed reset y per tank
KEYMAP, {8'h4F,8'h51,8'h50,8'h52, 8'h07,8'h16,8'h04,8'h1A}, packed {right,down,left,up} codes per tank; tank 0 = WASD, tank 1 = arrows

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blank
keycodes  in  8*N_KEYS  HID report; 0x00 = no key
tank_x  out  COORD_W*N_TANKS  packed top-left x
tank_y  out  COORD_W*N_TANKS  packed top-left y
tank_dir  out  2*N_TANKS  facing: 0 up, 1 right, 2 down, 3 left
blocked  out  N_TANKS  last attempted move rejected by collision
update_done  out  1  one-cycle pulse when frame update is complete
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (async, Reset_n=0): tank_x/tank_y = START_X/START_Y, tank_dir=0, blocked=0, update_done=0, overrun=0, FSM=IDLE, idx=0. Reset mid-update aborts with no partial commit visible after release.
- FSM states: IDLE, EVAL, DONE.
- IDLE: on frame_tick in cycle t, latch keycodes into key_reg and enter EVAL with idx=0 at t+1. Key changes after t have no effect this frame.
- EVAL: one tank per cycle; tank idx commits at end of cycle t+1+idx. After idx=N_TANKS-1, go to DONE.
- DONE (cycle t+1+N_TANKS): update_done=1 for exactly one cycle; return to IDLE.
- frame_tick while in EVAL or DONE: ignored; overrun set, cleared only by reset.
- Key decode per tank: a direction is pressed if its KEYMAP code equals any non-zero key_reg byte. Priority when several are held: up > down > left > right. No key: position, dir and blocked unchanged.
- Move: candidate = position ±STEP on one axis. Compute in COORD_W+1 bits, clamp to [MIN, MAX]; no wrap-around. At a boundary the tank stays put, dir still updates, and no blocked flag is raised.
- Collision: candidate overlaps tank j (j≠idx) iff |cx−xj| < TANK_SIZE and |cy−yj| < TANK_SIZE, using current registered positions. Any overlap: position kept, dir updated, blocked[idx]=1. Otherwise commit and set blocked[idx]=0.
- Tanks evaluate in index order. Lower indices commit first and are seen by later tanks, so on a contested square the lower index wins.
- Outputs are registered. Colour mapper reads positions freely; they are stable except during EVAL, which falls within vblank.

Decomposition:
- Package tank_pkg: dir_t enum (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT), fsm state enum, default keymap constants (KEY_W=8'h1A, KEY_A=8'h04, KEY_S=8'h16, KEY_D=8'h07, KEY_UP=8'h52, KEY_DN=8'h51, KEY_LT=8'h50, KEY_RT=8'h4F).
- One sub-module, tank_overlap_chk: combinational test of a candidate box against N_TANKS−1 others, with an exclude index.

Test Plan (defaults, N_TANKS=2):
- Assert reset, release -> tank0 (100,200), tank1 (300,200), dir 0/0, blocked 00, overrun 0; no update_done without a tick.
- keycodes={0x07}, tick at t -> tank0 x=101 dir=1 at t+2, tank1 unchanged, update_done high only at t+3.
- keycodes={0x1A,0x16,0x4F} -> tank0 y=199 (up beats down), tank1 x=301 dir=1, both in one frame.
- Tank0 forced to x=0, hold 0x04 for 3 frames -> x stays 0, dir=3, blocked[0]=0.
- Tank0 at (283,200), tank1 at (300,200), hold 0x07 -> frame 1 x=284 blocked=0; frame 2 x=284 blocked[0]=1; release key -> blocked[0] stays 1.
- Tick at t, second tick at t+1 -> overrun=1, single update only; Reset_n low at t+2 -> start positions restored, overrun=0, FSM idle.
